// File: rtl/wb_sram_banked_pkg.sv
// Shared types, constants and helpers for the banked Wishbone SRAM slave.
package wb_sram_pkg;

  localparam int BANK_WORDS = 1024;
  localparam int BANK_AW    = 10;
  localparam int DW         = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    PIPE,
    ACK
  } wb_state_t;

  // Each byte select opens all eight bit-enables of its byte lane.
  function automatic logic [DW-1:0] sel_to_ben(input logic [3:0] sel);
    logic [DW-1:0] ben;
    for (int b = 0; b < 4; b++) begin
      ben[8*b +: 8] = {8{sel[b]}};
    end
    return ben;
  endfunction

endpackage

// File: rtl/EF_SRAM_1024x32.sv
// Behavioural model of the 1024x32 SRAM macro: synchronous read, per-bit write enables.
// Power pins appear only when USE_POWER_PINS is defined.
module EF_SRAM_1024x32 (
`ifdef USE_POWER_PINS
  inout  wire         vpwrac,
  inout  wire         vpwrpc,
`endif
  output logic [31:0] DO,
  output logic        ScanOutCC,
  input  logic [31:0] DI,
  input  logic [31:0] BEN,
  input  logic [9:0]  AD,
  input  logic        EN,
  input  logic        R_WB,
  input  logic        CLKin,
  input  logic        WLBI,
  input  logic        WLOFF,
  input  logic        TM,
  input  logic        SM,
  input  logic        ScanInCC,
  input  logic        ScanInDL,
  input  logic        ScanInDR
);

  logic [31:0] mem [1024];
  logic        unused_tie;

  assign ScanOutCC  = 1'b0;
  assign unused_tie = ^{WLBI, WLOFF, TM, SM, ScanInCC, ScanInDL, ScanInDR};

  always_ff @(posedge CLKin) begin
    if (EN) begin
      if (R_WB) begin
        DO <= mem[AD];
      end else begin
        mem[AD] <= (mem[AD] & ~BEN) | (DI & BEN);
      end
    end
  end

endmodule

// File: rtl/wb_sram_banked_bank_array.sv
// NUM_BANKS SRAM macros sharing address/data, with a one-hot enable and a read mux
// indexed by the registered bank number.
module sram_bank_array
  import wb_sram_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BW        = 1
) (
`ifdef USE_POWER_PINS
  inout  wire               vpwrac,
  inout  wire               vpwrpc,
`endif
  input  logic              CLKin,
  input  logic              en,
  input  logic [BW-1:0]     bank,
  input  logic              r_wb,
  input  logic [BANK_AW-1:0] row,
  input  logic [DW-1:0]     ben,
  input  logic [DW-1:0]     di,
  output logic [DW-1:0]     rd_data
);

  logic [DW-1:0] bank_do        [NUM_BANKS];
  logic [DW-1:0] bank_do_masked [NUM_BANKS];

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic bank_hit;
      logic scan_out_unused;

      assign bank_hit = (bank == BW'(gi));

      EF_SRAM_1024x32 u_sram (
`ifdef USE_POWER_PINS
        .vpwrac   (vpwrac),
        .vpwrpc   (vpwrpc),
`endif
        .DO       (bank_do[gi]),
        .ScanOutCC(scan_out_unused),
        .DI       (di),
        .BEN      (ben),
        .AD       (row),
        .EN       (en & bank_hit),
        .R_WB     (r_wb),
        .CLKin    (CLKin),
        .WLBI     (1'b0),
        .WLOFF    (1'b0),
        .TM       (1'b0),
        .SM       (1'b0),
        .ScanInCC (1'b0),
        .ScanInDL (1'b0),
        .ScanInDR (1'b0)
      );

      assign bank_do_masked[gi] = bank_hit ? bank_do[gi] : '0;
    end
  endgenerate

  // AND-OR mux: only the hit bank contributes, so no out-of-bounds index is ever formed.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      rd_data = rd_data | bank_do_masked[i];
    end
  end

endmodule

// File: rtl/wb_sram_banked.sv
// Wishbone-classic slave mapping NUM_BANKS 1024x32 SRAM macros onto one word space.
// Optional: define SRAM_WB_ERR_EN to answer out-of-range accesses with wbs_err_o.
module wb_sram_banked
  import wb_sram_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int REG_OUT   = 0,
  parameter int AW        = $clog2(NUM_BANKS) + 10
) (
`ifdef USE_POWER_PINS
  inout  wire         vpwrac,
  inout  wire         vpwrpc,
`endif
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int BW = (AW > BANK_AW) ? (AW - BANK_AW) : 1;

  wb_state_t           state_reg, state_next;
  logic                req_we_reg;
  logic [3:0]          req_sel_reg;
  logic [BANK_AW-1:0]  req_row_reg;
  logic [BW-1:0]       req_bank_reg;
  logic [DW-1:0]       req_dat_reg;
  logic                req_in_range_reg;
  logic [DW-1:0]       dat_reg;

  logic [BANK_AW-1:0]  adr_row;
  logic [BW-1:0]       adr_bank;
  logic                adr_in_range;
  logic                accept;
  logic                mac_en;
  logic                mac_r_wb;
  logic                resp_slot;
  logic                resp_ok;
  logic                dat_load;
  logic [DW-1:0]       bank_rd;
  logic [DW-1:0]       rd_word;
  logic                unused_adr;

  assign adr_row    = wbs_adr_i[BANK_AW+1:2];
  assign unused_adr = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};

  generate
    if (AW > BANK_AW) begin : g_bank_field
      assign adr_bank = wbs_adr_i[AW+1:BANK_AW+2];
    end else begin : g_single_bank
      assign adr_bank = '0;
    end
  endgenerate

  assign adr_in_range = (int'(adr_bank) < NUM_BANKS);
  assign accept       = (state_reg == IDLE) && wbs_cyc_i && wbs_stb_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg        <= IDLE;
      req_we_reg       <= 1'b0;
      req_sel_reg      <= '0;
      req_row_reg      <= '0;
      req_bank_reg     <= '0;
      req_dat_reg      <= '0;
      req_in_range_reg <= 1'b0;
      dat_reg          <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        req_we_reg       <= wbs_we_i;
        req_sel_reg      <= wbs_sel_i;
        req_row_reg      <= adr_row;
        req_bank_reg     <= adr_bank;
        req_dat_reg      <= wbs_dat_i;
        req_in_range_reg <= adr_in_range;
      end
      if (dat_load) begin
        dat_reg <= rd_word;
      end
    end
  end

  // The macro sees EN only in ACCESS, so it samples exactly once per transfer
  // even when the master abandons the cycle.
  always_comb begin
    state_next = state_reg;
    mac_en     = 1'b0;
    mac_r_wb   = 1'b1;
    resp_slot  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        mac_en   = req_in_range_reg;
        mac_r_wb = ~req_we_reg;
        if (!wbs_cyc_i) begin
          state_next = IDLE;
        end else if (REG_OUT != 0) begin
          state_next = PIPE;
        end else begin
          state_next = ACK;
        end
      end
      PIPE: begin
        state_next = wbs_cyc_i ? ACK : IDLE;
      end
      ACK: begin
        resp_slot  = wbs_cyc_i;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef SRAM_WB_ERR_EN
  assign resp_ok   = req_in_range_reg;
  assign wbs_err_o = resp_slot & ~req_in_range_reg;
`else
  assign resp_ok   = 1'b1;
  assign wbs_err_o = 1'b0;
`endif

  assign wbs_ack_o = resp_slot & resp_ok;

  sram_bank_array #(
    .NUM_BANKS(NUM_BANKS),
    .BW       (BW)
  ) u_banks (
`ifdef USE_POWER_PINS
    .vpwrac (vpwrac),
    .vpwrpc (vpwrpc),
`endif
    .CLKin  (wb_clk_i),
    .en     (mac_en),
    .bank   (req_bank_reg),
    .r_wb   (mac_r_wb),
    .row    (req_row_reg),
    .ben    (sel_to_ben(req_sel_reg)),
    .di     (req_dat_reg),
    .rd_data(bank_rd)
  );

  // Out-of-range reads never enabled a bank, so force zero rather than stale DO.
  assign rd_word = req_in_range_reg ? bank_rd : '0;

  always_comb begin
    if (REG_OUT != 0) begin
      dat_load = (state_reg == PIPE) && wbs_cyc_i && !req_we_reg && resp_ok;
    end else begin
      dat_load = wbs_ack_o && !req_we_reg;
    end
  end

  assign wbs_dat_o = ((REG_OUT == 0) && dat_load) ? rd_word : dat_reg;

endmodule
